// File: rtl/gpu_pkg.sv
// Shared GPU definitions: pixel-index field widths and the pixel write record.
// The width helper is the single source for the row/column bit split used by
// both the GPU pixel-index math and the pixel sink address decode.
package gpu;

    localparam int H_RES_DEFAULT      = 320;
    localparam int V_RES_DEFAULT      = 240;
    localparam int PIXEL_BITS_DEFAULT = 16;

    // Bits needed to hold a coordinate in 0..n-1.
    function automatic int res_bits(input int n);
        return $clog2(n);
    endfunction

    localparam int COL_BITS_DEFAULT   = res_bits(H_RES_DEFAULT);
    localparam int ROW_BITS_DEFAULT   = res_bits(V_RES_DEFAULT);
    localparam int INDEX_BITS_DEFAULT = COL_BITS_DEFAULT + ROW_BITS_DEFAULT;

    // Linear pixel index plus pixel value, at the default resolution.
    typedef struct packed {
        logic [INDEX_BITS_DEFAULT-1:0] index;
        logic [PIXEL_BITS_DEFAULT-1:0] data;
    } pixel_write_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two (>= 2).
// Ports: clock, reset_n (async active-low), push/din, pop, head (entry at the
// read pointer), full, empty. Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage is not reset; empty gates every use of head.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Avalon-MM write-only slave terminating the GPU pixel write-out port.
// Ports: clock, reset_n (async active-low); s_address/s_writedata/s_write/
// s_waitrequest (Avalon slave); fb_addr/fb_data/fb_we/fb_ready (framebuffer
// write port with backpressure); frame_done (one-cycle pulse per completed
// frame); err_count (saturating rejected-write count); clear (sync).
module pixel_sink
    import gpu::*;
#(
    parameter int          H_RESOLUTION = 320,
    parameter int          V_RESOLUTION = 240,
    parameter int          PIXEL_BITS   = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDRESS = 32'hC800_0000
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic [31:0]                               s_address,
    input  logic [PIXEL_BITS-1:0]                     s_writedata,
    input  logic                                      s_write,
    output logic                                      s_waitrequest,
    output logic [res_bits(H_RESOLUTION)+res_bits(V_RESOLUTION)-1:0] fb_addr,
    output logic [PIXEL_BITS-1:0]                     fb_data,
    output logic                                      fb_we,
    input  logic                                      fb_ready,
    output logic                                      frame_done,
    output logic [15:0]                               err_count,
    input  logic                                      clear
);
    localparam int COL_BITS = res_bits(H_RESOLUTION);
    localparam int ROW_BITS = res_bits(V_RESOLUTION);
    localparam int IDX_BITS = COL_BITS + ROW_BITS;
    localparam int ROW_MSB  = COL_BITS + ROW_BITS;
    localparam logic [IDX_BITS-1:0] LAST_PIX = IDX_BITS'(H_RESOLUTION * V_RESOLUTION - 1);

    typedef struct packed {
        logic [IDX_BITS-1:0]   index;
        logic [PIXEL_BITS-1:0] data;
    } entry_t;

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                base_ok;
    logic                addr_ok;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    entry_t              wr_entry;
    entry_t              head;

    logic                ready_q;
    logic [IDX_BITS-1:0] pix_q;
    logic                frame_done_q;
    logic [15:0]         err_q;

    assign col     = s_address[COL_BITS:1];
    assign row     = s_address[ROW_MSB:COL_BITS+1];
    assign base_ok = (s_address[31:ROW_MSB+1] == BASE_ADDRESS[31:ROW_MSB+1]);
    // One extra bit on the compare so power-of-two resolutions still work.
    assign addr_ok = base_ok && !s_address[0]
                  && ({1'b0, col} < (COL_BITS+1)'(H_RESOLUTION))
                  && ({1'b0, row} < (ROW_BITS+1)'(V_RESOLUTION));

    assign wr_entry.index = IDX_BITS'(row) * IDX_BITS'(H_RESOLUTION) + IDX_BITS'(col);
    assign wr_entry.data  = s_writedata;

    // ready_q holds off the master for the first cycle out of reset.
    assign s_waitrequest = fifo_full | ~ready_q;
    assign accept        = s_write & ~s_waitrequest;
    assign push          = accept & addr_ok;
    assign pop           = fb_we & fb_ready;

    sync_fifo #(
        .WIDTH (IDX_BITS + PIXEL_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (wr_entry),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fb_we      = ~fifo_empty;
    assign fb_addr    = fifo_empty ? '0 : head.index;
    assign fb_data    = fifo_empty ? '0 : head.data;
    assign frame_done = frame_done_q;
    assign err_count  = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= 1'b0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            // clear overrides both the pop count and a rejected write.
            if (clear) begin
                pix_q <= '0;
                err_q <= '0;
            end else begin
                if (pop) begin
                    if (pix_q == LAST_PIX) begin
                        pix_q        <= '0;
                        frame_done_q <= 1'b1;
                    end else begin
                        pix_q <= pix_q + 1'b1;
                    end
                end
                if (accept && !addr_ok && (err_q != 16'hFFFF)) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pixel_sink.md
# pixel_sink

Avalon-MM write-only slave that terminates the GPU's pixel write-out master port and receives its 16-bit pixel writes. It decodes each pixel-buffer address into a row and column and rejects malformed or out-of-range addresses. Valid pixels are buffered in a small FIFO and drained into a single-port framebuffer memory write port that has its own backpressure. It also counts completed frames so the host, or a display controller, knows when a full image has landed.

## Interface
- H_RESOLUTION, 320, pixels per row.
- V_RESOLUTION, 240, rows per frame.
- PIXEL_BITS, 16, pixel width.
- FIFO_DEPTH, 4, buffered pixels; power of two, at least 2.
- BASE_ADDRESS, 32'hC800_0000, pixel-buffer base address; bits above the row field must match it.
- clock  in  1  system clock. One clock domain only.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  32  byte address. Bit 0 is 0, column is in [COL_BITS:1], row is in [COL_BITS+ROW_BITS:COL_BITS+1]. COL_BITS = $clog2(H_RESOLUTION), ROW_BITS = $clog2(V_RESOLUTION).
- s_writedata  in  PIXEL_BITS  pixel value.
- s_write  in  1  write request.
- s_waitrequest  out  1  stall; the request is held by the master while this is 1.
- fb_addr  out  ROW_BITS+COL_BITS  linear pixel index, row*H_RESOLUTION+col.
- fb_data  out  PIXEL_BITS  pixel to store.
- fb_we  out  1  framebuffer write strobe.
- fb_ready  in  1  framebuffer accepts the write this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- err_count  out  16  saturating count of rejected writes.
- clear  in  1  synchronous. Zeroes the frame pixel counter and err_count.

## Operation
- **Accept:** a write is accepted on any cycle with s_write=1 and s_waitrequest=0.
- **Validation, done in the accept cycle:**
  - the address bits above the row field must equal the same bits of BASE_ADDRESS;
  - bit 0 must be 0;
  - col must be < H_RESOLUTION;
  - row must be < V_RESOLUTION.
- **Valid write:** push {row*H_RESOLUTION+col, s_writedata}. The multiply and add are unsigned, at ROW_BITS+COL_BITS width.
- **Invalid write:** still accepted, so the master is never deadlocked. Nothing is enqueued, and err_count increments, saturating at 16'hFFFF.
- **s_waitrequest:** equals FIFO full, using the registered occupancy. It is 1 while reset_n=0 and on the first cycle after reset release.
- **Drain:**
  - fb_we = FIFO not empty, and fb_addr/fb_data come from the FIFO head.
  - The entry is popped on any cycle where fb_we=1 and fb_ready=1.
  - fb_addr and fb_data hold stable while fb_ready=0.
- **Push and pop in the same cycle:** allowed when the FIFO is not full; occupancy is unchanged. No push can happen while full, because waitrequest is asserted.
- **Frame counter:**
  - Counts pops, over the range 0..H*V-1.
  - The pop that takes it from H*V-1 wraps it to 0 and raises frame_done on the next cycle for exactly one cycle.
- **clear:**
  - Zeroes the pixel counter and err_count and suppresses a pending frame_done.
  - FIFO contents are untouched and keep draining.
  - clear wins over a simultaneous pop (that pop is not counted) and over a simultaneous invalid write (err_count becomes 0).
- **Reset mid-operation:** the FIFO is flushed and in-flight pixels are lost. The master must reissue them.

## Timing
- **Reset values:** s_waitrequest=1, fb_we=0, fb_addr=0, fb_data=0, frame_done=0, err_count=0.
- **Latency:** write accepted in cycle N, then fb_we=1 with that pixel in cycle N+1 if the FIFO was empty.
- **Throughput:** one pixel per cycle with fb_ready held at 1.
- **frame_done:** asserted in the cycle after the completing pop.
- **err_count:** visible in the cycle after the rejected write.

## Structure
- Add to package gpu:
  - typedef struct packed pixel_write_t {index, data};
  - a localparam or function for the COL_BITS and ROW_BITS derivation, shared with the GPU's pixel-index math.
- One sub-module, sync_fifo, parameterised by width and depth. It has push, pop, full, empty, and head outputs, and an async active-low reset.
- Decode, validation, and the frame and error counters live in pixel_sink itself.

## Test plan
- **Single write:** with fb_ready=1, write address 32'hC800_080A with data 16'hF800. Required: in the next cycle fb_we=1, fb_addr=645, fb_data=16'hF800, and err_count=0.
- **Out-of-range column:** write address 32'hC800_0280 (col 320). Required: fb_we stays 0 and err_count=1. Repeat with address 32'hC800_0001 (odd) and 32'h0800_0000 (wrong base): err_count=3.
- **Backpressure:**
  - Hold fb_ready=0 and issue 5 back-to-back valid writes. Required: 4 are accepted, then s_waitrequest=1.
  - Raise fb_ready. Required: 5 pixels reach the framebuffer in order, one per cycle, with the 5th accepted the cycle after the first pop.
- **Full frame:** stream 76800 valid writes. Required: exactly one frame_done pulse, one cycle after the 76800th fb_we&&fb_ready. A further 76800 writes give a second pulse.
- **clear:** assert clear together with an invalid write and with the 76799th pop. Required: err_count=0, and no frame_done until 76800 further pops.
- **Reset mid-operation:** with 3 pixels queued and fb_ready=0, pulse reset_n low. Required: fb_we=0 and s_waitrequest=1 during reset; after release there is no residual write and the counters are 0.
